// File: rtl/data_register_fifo.sv
// Register-side buffering stage: a TX FIFO fed by the register write strobe and
// an RX FIFO drained by the register read strobe, with fill counts and sticky overflow.
module data_register_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH_LOG2    = 4,
    parameter int BLOCKING_READ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      writeData,
    input  logic                  writeData_en,
    output logic                  writeData_busy,
    output logic [WIDTH-1:0]      readData,
    input  logic                  readData_en,
    output logic                  readData_busy,
    output logic [WIDTH-1:0]      tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_overflow,
    input  logic                  clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [WIDTH-1:0] rx_mem [DEPTH];

    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic          rx_overflow_q, rx_overflow_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;

    always_comb begin
        tx_empty = (tx_wptr_q == tx_rptr_q);
        tx_full  = (tx_wptr_q[PW-1] != tx_rptr_q[PW-1]) &&
                   (tx_wptr_q[PW-2:0] == tx_rptr_q[PW-2:0]);
        rx_empty = (rx_wptr_q == rx_rptr_q);
        rx_full  = (rx_wptr_q[PW-1] != rx_rptr_q[PW-1]) &&
                   (rx_wptr_q[PW-2:0] == rx_rptr_q[PW-2:0]);

        // clear wins over every strobe in the same cycle
        tx_push = writeData_en && !tx_full && !clear;
        tx_pop  = tx_ready && !tx_empty && !clear;
        rx_push = rx_valid && !rx_full && !clear;
        rx_pop  = readData_en && !rx_empty && !clear;

        tx_wptr_d     = tx_push ? tx_wptr_q + PW'(1) : tx_wptr_q;
        tx_rptr_d     = tx_pop  ? tx_rptr_q + PW'(1) : tx_rptr_q;
        rx_wptr_d     = rx_push ? rx_wptr_q + PW'(1) : rx_wptr_q;
        rx_rptr_d     = rx_pop  ? rx_rptr_q + PW'(1) : rx_rptr_q;
        rx_overflow_d = rx_overflow_q || (rx_valid && rx_full);
        if (clear) begin
            tx_wptr_d     = '0;
            tx_rptr_d     = '0;
            rx_wptr_d     = '0;
            rx_rptr_d     = '0;
            rx_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            tx_wptr_q     <= tx_wptr_d;
            tx_rptr_q     <= tx_rptr_d;
            rx_wptr_q     <= rx_wptr_d;
            rx_rptr_q     <= rx_rptr_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    // storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q[PW-2:0]] <= writeData;
        if (rx_push) rx_mem[rx_wptr_q[PW-2:0]] <= rx_data;
    end

    always_comb begin
        writeData_busy = tx_full;
        tx_valid       = !tx_empty;
        tx_data        = tx_mem[tx_rptr_q[PW-2:0]];
        rx_ready       = !rx_full;
        readData       = rx_empty ? '0 : rx_mem[rx_rptr_q[PW-2:0]];
        readData_busy  = (BLOCKING_READ != 0) && rx_empty;
        tx_count       = tx_wptr_q - tx_rptr_q;
        rx_count       = rx_wptr_q - rx_rptr_q;
        rx_overflow    = rx_overflow_q;
    end

endmodule

// File: doc/data_register_fifo.md
Name: data_register_fifo

Overview:
- Buffering stage directly behind a peripheral data register. It takes the register's write strobe/data and pushes it into a TX FIFO toward a serial-style core. It returns RX FIFO head data to the register's read port and pops on the read strobe.
- It decouples bus accesses from the core's byte rate and exposes fill counts and a sticky RX overflow flag for a neighbouring status register.

Parameters:
- WIDTH, 8, data width of both FIFOs and of the register-side data ports (1..32).
- DEPTH_LOG2, 4, log2 of entries per FIFO (DEPTH = 16).
- BLOCKING_READ, 0, when 1, a read of an empty RX FIFO stalls the bus via readData_busy; when 0, it returns zero and does not stall.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- writeData  in  WIDTH  data from register write strobe.
- writeData_en  in  1  register write strobe; TX push request.
- writeData_busy  out  1  TX FIFO full; stalls the bus write.
- readData  out  WIDTH  RX FIFO head, or zero when empty.
- readData_en  in  1  register read strobe; RX pop request.
- readData_busy  out  1  RX empty stall (only when BLOCKING_READ=1).
- tx_data  out  WIDTH  TX FIFO head to core.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  core accepts tx_data this cycle.
- rx_data  in  WIDTH  data from core.
- rx_valid  in  1  core presents rx_data this cycle; core does not wait for rx_ready.
- rx_ready  out  1  RX FIFO not full.
- tx_count  out  DEPTH_LOG2+1  TX entries held, 0..DEPTH.
- rx_count  out  DEPTH_LOG2+1  RX entries held, 0..DEPTH.
- rx_overflow  out  1  sticky: RX data dropped.
- clear  in  1  synchronous flush of both FIFOs and the overflow flag.

Behaviour:
- Each FIFO uses read/write pointers of DEPTH_LOG2+1 bits that wrap naturally.
  - Empty: pointers equal.
  - Full: MSBs differ and the lower bits are equal.
  - Count = write pointer minus read pointer, modulo 2^(DEPTH_LOG2+1).
- Storage is a plain register array; its contents are not reset. Heads are show-ahead: tx_data and readData reflect the entry at the read pointer combinationally, with no read latency.
- Reset (rst low, async) values:
  - pointers 0, tx_count 0, rx_count 0, rx_overflow 0;
  - tx_valid 0, rx_ready 1, writeData_busy 0;
  - readData 0, readData_busy = BLOCKING_READ, tx_data undefined-but-stable.
- TX push: on an edge with writeData_en=1 and full=0, store writeData[WIDTH-1:0] and advance the write pointer. writeData_busy = TX full, combinational from current state; a same-cycle pop does not release it.
- TX pop: on an edge with tx_valid && tx_ready, advance the read pointer.
- TX push and pop in the same cycle (not full, not empty): both happen and the count is unchanged.
- RX push: on an edge with rx_valid && rx_ready, store rx_data.
  - If rx_valid=1 while full, the data is dropped and rx_overflow is set on that edge, even if a bus pop occurs the same cycle.
- RX pop: on an edge with readData_en=1 and RX not empty, advance the read pointer. readData shows the popped value during that cycle.
- RX read of an empty FIFO with BLOCKING_READ=0: readData=0, readData_busy=0, no pointer change.
- RX read of an empty FIFO with BLOCKING_READ=1: readData_busy=1 while empty; the pop happens on the first cycle data is present.
- Register-side strobes are one cycle per access when busy=0. Each high cycle of writeData_en or readData_en with busy low is exactly one push or pop.
- clear=1 has priority over all push/pop that cycle:
  - pointers set to 0, rx_overflow set to 0;
  - strobes in that cycle are ignored, and an overflow in the same cycle is also cleared.
- rx_overflow clears only via clear or reset.
- Reset asserted mid-transfer discards all contents; outputs take reset values immediately.

Test Plan:
- Reset, then write 0x11,0x22,0x33 via writeData_en with tx_ready=0 -> tx_count=3, tx_valid=1, tx_data=0x11. Then tx_ready=1 for 3 cycles -> tx_data 0x11,0x22,0x33 in order, then tx_valid=0, tx_count=0.
- Write 16 values with tx_ready=0 -> tx_count=16, writeData_busy=1. A 17th write is stalled with no push. One tx_ready pulse -> busy drops next cycle, and the write completes at count 16.
- Core pushes 0xA5 then 0x5A on rx_valid -> rx_count=2, readData=0xA5. Read strobe -> pop, readData=0x5A. With BLOCKING_READ=0, a read at empty -> readData=0x00, busy=0.
- Fill RX to 16 and pulse rx_valid with 0xFF -> rx_ready=0, data dropped, rx_overflow=1, rx_count=16. Pulse clear -> rx_count=0, rx_overflow=0.
- Simultaneous TX push+pop at count 5 for 20 cycles -> count stays 5, pointers wrap past 16, data order preserved.
- With BLOCKING_READ=1, read strobe held at empty -> readData_busy=1. rx_valid with 0x42 -> pop on the next edge, busy=0, readData=0x42. Assert rst low mid-hold -> all counts 0 asynchronously.
